// File: rtl/bht_gshare_if.sv
// Fetch-side prediction and resolve-side update bus of the branch history table.
// The slave modport is the table; the master modport is the frontend driving it.
interface bht_gshare_if #(
   parameter int unsigned VLEN            = 39,
   parameter int unsigned INSTR_PER_FETCH = 2,
   parameter int unsigned HIST_LEN        = 8
);
   logic                       flush_i;
   logic                       debug_mode_i;
   logic [VLEN-1:0]            vpc_i;
   logic [INSTR_PER_FETCH-1:0] pred_valid_o;
   logic [INSTR_PER_FETCH-1:0] pred_taken_o;
   logic [HIST_LEN-1:0]        hist_o;
   logic                       upd_valid_i;
   logic [VLEN-1:0]            upd_pc_i;
   logic                       upd_taken_i;
   logic [HIST_LEN-1:0]        upd_hist_i;
   logic                       flush_busy_o;

   modport slave (
      input  flush_i, debug_mode_i, vpc_i, upd_valid_i, upd_pc_i, upd_taken_i, upd_hist_i,
      output pred_valid_o, pred_taken_o, hist_o, flush_busy_o
   );

   modport master (
      output flush_i, debug_mode_i, vpc_i, upd_valid_i, upd_pc_i, upd_taken_i, upd_hist_i,
      input  pred_valid_o, pred_taken_o, hist_o, flush_busy_o
   );
endinterface

// File: rtl/bht_gshare.sv
// Saturating-counter branch history table, INSTR_PER_FETCH predictions per fetch, row-walking flush.
// Define BHT_GSHARE_EN to XOR row indices with a global history register (gshare).
module bht_gshare #(
   parameter int unsigned NR_ENTRIES      = 1024,
   parameter int unsigned INSTR_PER_FETCH = 2,
   parameter int unsigned VLEN            = 39,
   parameter int unsigned RVC             = 1,
   parameter int unsigned CTR_BITS        = 2,
   parameter int unsigned HIST_LEN        = 8
) (
   input logic          clk_i,
   input logic          rst_i,
   bht_gshare_if.slave  bus
);
   localparam int unsigned NR_ROWS  = NR_ENTRIES / INSTR_PER_FETCH;
   localparam int unsigned ROW_BITS = $clog2(NR_ROWS);
   localparam int unsigned COL_BITS = $clog2(INSTR_PER_FETCH);
   localparam int unsigned OFFSET   = (RVC != 0) ? 1 : 2;
   localparam int unsigned IDX_LSB  = COL_BITS + OFFSET;
   localparam logic [CTR_BITS-1:0] CTR_MAX = '1;
   localparam logic [CTR_BITS-1:0] WEAK    = {1'b1, {(CTR_BITS-1){1'b0}}};

   typedef enum logic {IDLE, FLUSH} state_e;

   state_e                                             state_q, state_d;
   logic [ROW_BITS-1:0]                                row_cnt_q, row_cnt_d;
   logic [NR_ROWS-1:0][INSTR_PER_FETCH-1:0]            valid_q;
   logic [NR_ROWS-1:0][INSTR_PER_FETCH-1:0][CTR_BITS-1:0] ctr_q;

   logic [HIST_LEN-1:0] hist;
   logic [ROW_BITS-1:0] fetch_row, upd_row;
   logic [COL_BITS-1:0] upd_col;
   logic [CTR_BITS-1:0] ctr_old, ctr_new;
   logic                busy, upd_en;
   logic                unused_ok;

   // Updates landing during or coincident with a flush are dropped, never queued.
   assign upd_en = bus.upd_valid_i && !bus.debug_mode_i && (state_q == IDLE) && !bus.flush_i;
   assign unused_ok = ^{bus.vpc_i, bus.upd_pc_i, bus.upd_hist_i};

`ifdef BHT_GSHARE_EN
   logic [HIST_LEN-1:0] ghr_q, ghr_shift;

   if (HIST_LEN == 1) begin : g_hist1
      assign ghr_shift = bus.upd_taken_i;
   end else begin : g_histn
      assign ghr_shift = {ghr_q[HIST_LEN-2:0], bus.upd_taken_i};
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i)            ghr_q <= '0;
      else if (bus.flush_i) ghr_q <= '0;
      else if (upd_en)      ghr_q <= ghr_shift;
   end

   assign hist      = ghr_q;
   assign fetch_row = bus.vpc_i[IDX_LSB+ROW_BITS-1:IDX_LSB] ^ ROW_BITS'(hist);
   assign upd_row   = bus.upd_pc_i[IDX_LSB+ROW_BITS-1:IDX_LSB] ^ ROW_BITS'(bus.upd_hist_i);
`else
   assign hist      = '0;
   assign fetch_row = bus.vpc_i[IDX_LSB+ROW_BITS-1:IDX_LSB];
   assign upd_row   = bus.upd_pc_i[IDX_LSB+ROW_BITS-1:IDX_LSB];
`endif

   // Word-offset fetch packs one instruction per row, so updates always land in column 0.
   if (RVC != 0) begin : g_col_rvc
      assign upd_col = bus.upd_pc_i[IDX_LSB-1:OFFSET];
   end else begin : g_col_word
      assign upd_col = '0;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q   <= IDLE;
         row_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         row_cnt_q <= row_cnt_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      row_cnt_d = row_cnt_q;
      case (state_q)
         IDLE: if (bus.flush_i) begin
            state_d   = FLUSH;
            row_cnt_d = '0;
         end
         FLUSH: begin
            if (bus.flush_i) begin
               row_cnt_d = '0;
            end else if (row_cnt_q == ROW_BITS'(NR_ROWS-1)) begin
               state_d   = IDLE;
               row_cnt_d = '0;
            end else begin
               row_cnt_d = row_cnt_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      busy             = (state_q == FLUSH);
      bus.flush_busy_o = busy;
   end

   always_comb begin
      ctr_old = ctr_q[upd_row][upd_col];
      ctr_new = ctr_old;
      if (bus.upd_taken_i) begin
         if (ctr_old != CTR_MAX) ctr_new = ctr_old + 1'b1;
      end else if (ctr_old != '0) begin
         ctr_new = ctr_old - 1'b1;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         valid_q <= '0;
         ctr_q   <= '0;
      end else if (state_q == FLUSH) begin
         valid_q[row_cnt_q] <= '0;
         for (int i = 0; i < INSTR_PER_FETCH; i++) ctr_q[row_cnt_q][i] <= WEAK;
      end else if (upd_en) begin
         valid_q[upd_row][upd_col] <= 1'b1;
         ctr_q[upd_row][upd_col]   <= ctr_new;
      end
   end

   always_comb begin
      for (int i = 0; i < INSTR_PER_FETCH; i++) begin
         bus.pred_taken_o[i] = ctr_q[fetch_row][i][CTR_BITS-1];
         bus.pred_valid_o[i] = valid_q[fetch_row][i] & ~busy;
      end
      bus.hist_o = hist;
   end
endmodule
